// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: imem request/response, branch redirect, and the decode-side output slot.
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32
);
  logic                  imem_req_valid;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_req_ready;
  logic                  imem_resp_valid;
  logic [INST_WIDTH-1:0] imem_resp_data;
  logic                  branch_taken;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  id_ready;
  logic                  if_valid;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic [INST_WIDTH-1:0] if_inst;
  logic                  misaligned_fault;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst, misaligned_fault,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, branch_taken, branch_target, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst, misaligned_fault,
    output imem_req_ready, imem_resp_valid, imem_resp_data, branch_taken, branch_target, id_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, keeps one imem read outstanding, and feeds decode through a
// one-entry output slot. Redirects kill the in-flight response; misaligned targets lock up.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FAULT} state_t;

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  kill_q, kill_d;
  logic                  if_valid_q, if_valid_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [INST_WIDTH-1:0] if_inst_q, if_inst_d;
  logic                  fault_q, fault_d;
  logic                  req_valid, req_fire;

  // Only ask for a new word when the slot is empty or draining this cycle.
  assign req_valid = (state_q == S_REQ) && (!if_valid_q || bus.id_ready) && !reset;
  assign req_fire  = req_valid && bus.imem_req_ready;

  assign bus.imem_req_valid   = req_valid;
  assign bus.imem_req_addr    = pc_q;
  assign bus.if_valid         = if_valid_q;
  assign bus.if_pc            = if_pc_q;
  assign bus.if_inst          = if_inst_q;
  assign bus.misaligned_fault = fault_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    fault_d    = fault_q;

    if (if_valid_q && bus.id_ready) if_valid_d = 1'b0;

    unique case (state_q)
      S_REQ: begin
        if (req_fire) begin
          state_d  = S_WAIT;
          req_pc_d = pc_q;
        end
      end
      S_WAIT: begin
        if (bus.imem_resp_valid) begin
          state_d = S_REQ;
          if (kill_q) begin
            kill_d = 1'b0;
          end else begin
            if_valid_d = 1'b1;
            if_pc_d    = req_pc_q;
            if_inst_d  = bus.imem_resp_data;
            pc_d       = req_pc_q + STEP;
          end
        end
      end
      default: ;
    endcase

    // Redirect overrides everything above; an outstanding or just-issued read must be killed.
    if (bus.branch_taken && state_q != S_FAULT) begin
      if_valid_d = 1'b0;
      if (bus.branch_target[1:0] != 2'b00) begin
        fault_d = 1'b1;
        kill_d  = 1'b0;
        state_d = S_FAULT;
      end else begin
        pc_d = bus.branch_target;
        if ((state_q == S_WAIT && !bus.imem_resp_valid) || (state_q == S_REQ && req_fire)) begin
          kill_d  = 1'b1;
          state_d = S_WAIT;
        end else begin
          kill_d  = 1'b0;
          state_d = S_REQ;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      fault_q    <= fault_d;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed cycle-by-cycle bench for instruction_fetch_unit; a second instance covers PC wrap.
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic rst_m, rst_b;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.ADDR_WIDTH(64), .INST_WIDTH(32)) bm ();
  instruction_fetch_unit_if #(.ADDR_WIDTH(64), .INST_WIDTH(32)) bb ();

  instruction_fetch_unit #(.ADDR_WIDTH(64), .INST_WIDTH(32), .RESET_PC(64'h0), .PC_STEP(4))
    dut_m (.clk(clk), .reset(rst_m), .bus(bm));
  instruction_fetch_unit #(.ADDR_WIDTH(64), .INST_WIDTH(32),
                           .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .PC_STEP(4))
    dut_b (.clk(clk), .reset(rst_b), .bus(bb));

  typedef struct {
    logic        rst, rdy, rv;
    logic [31:0] rd;
    logic        bt;
    logic [63:0] tg;
    logic        idr;
    logic        qv;
    logic [63:0] qa;
    logic        iv;
    logic [63:0] pc;
    logic [31:0] ins;
    logic        flt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic rdy, logic rv, logic [31:0] rd, logic bt,
                              logic [63:0] tg, logic idr, logic qv, logic [63:0] qa,
                              logic iv, logic [63:0] pc, logic [31:0] ins, logic flt);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rd = rd; v.bt = bt; v.tg = tg; v.idr = idr;
    v.qv = qv; v.qa = qa; v.iv = iv; v.pc = pc; v.ins = ins; v.flt = flt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Stimulus columns: rst rdy rv rd bt tgt idr | expected: req_valid req_addr if_valid if_pc if_inst fault
    // Sequential stream 0,4,8,C
    vq.push_back(mk(0,1,0,32'h0,  0,0,1, 1,64'h0, 0,0,0,0));
    vq.push_back(mk(0,1,1,32'h13, 0,0,1, 0,64'h0, 0,0,0,0));
    vq.push_back(mk(0,1,0,32'h0,  0,0,1, 1,64'h4, 1,64'h0,32'h13,0));
    vq.push_back(mk(0,1,1,32'h93, 0,0,1, 0,64'h0, 0,0,0,0));
    vq.push_back(mk(0,1,0,32'h0,  0,0,1, 1,64'h8, 1,64'h4,32'h93,0));
    vq.push_back(mk(0,1,1,32'h113,0,0,1, 0,64'h0, 0,0,0,0));
    vq.push_back(mk(0,1,0,32'h0,  0,0,1, 1,64'hC, 1,64'h8,32'h113,0));
    vq.push_back(mk(0,1,1,32'h193,0,0,1, 0,64'h0, 0,0,0,0));
    vq.push_back(mk(0,0,0,32'h0,  0,0,1, 1,64'h10,1,64'hC,32'h193,0));
    vq.push_back(mk(1,0,0,32'h0,  0,0,1, 0,64'h0, 0,0,0,0));
    // Decode stall holds the slot and blocks requests
    vq.push_back(mk(0,1,0,32'h0,  0,0,1, 1,64'h0, 0,0,0,0));
    vq.push_back(mk(0,1,1,32'h13, 0,0,1, 0,64'h0, 0,0,0,0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0,1,0,32'h0,0,0,0, 0,64'h0, 1,64'h0,32'h13,0));
    vq.push_back(mk(0,1,0,32'h0,  0,0,1, 1,64'h4, 1,64'h0,32'h13,0));
    vq.push_back(mk(0,1,1,32'h93, 0,0,1, 0,64'h0, 0,0,0,0));
    vq.push_back(mk(0,1,0,32'h0,  0,0,1, 1,64'h8, 1,64'h4,32'h93,0));
    // Redirect to 0x100 while waiting on addr 8; its response comes two cycles later
    vq.push_back(mk(0,1,0,32'h0,  1,64'h100,1, 0,64'h0, 0,0,0,0));
    vq.push_back(mk(0,1,0,32'h0,  0,0,1, 0,64'h0, 0,0,0,0));
    vq.push_back(mk(0,1,1,32'h113,0,0,1, 0,64'h0, 0,0,0,0));
    vq.push_back(mk(0,1,0,32'h0,  0,0,1, 1,64'h100,0,0,0,0));
    vq.push_back(mk(0,1,1,32'h2013,0,0,1,0,64'h0, 0,0,0,0));
    vq.push_back(mk(0,0,0,32'h0,  0,0,1, 1,64'h104,1,64'h100,32'h2013,0));
    // Redirect coinciding with a response, then with a request handshake
    vq.push_back(mk(0,1,0,32'h0,  0,0,1, 1,64'h104,0,0,0,0));
    vq.push_back(mk(0,1,1,32'h2093,1,64'h40,1,0,64'h0,0,0,0,0));
    vq.push_back(mk(0,1,0,32'h0,  1,64'h40,1, 1,64'h40,0,0,0,0));
    vq.push_back(mk(0,1,1,32'h813,0,0,1, 0,64'h0, 0,0,0,0));
    vq.push_back(mk(0,1,0,32'h0,  0,0,1, 1,64'h40,0,0,0,0));
    vq.push_back(mk(0,1,1,32'h813,0,0,1, 0,64'h0, 0,0,0,0));
    vq.push_back(mk(0,0,0,32'h0,  0,0,1, 1,64'h44,1,64'h40,32'h813,0));
    // Misaligned target: sticky fault, no requests, redirects and responses ignored
    vq.push_back(mk(0,0,0,32'h0,  1,64'h102,1, 1,64'h44,0,0,0,0));
    for (int i = 0; i < 10; i++)
      vq.push_back(mk(0,1,1,32'hDEAD,(i == 3),64'h0,1, 0,64'h0, 0,0,0,1));
    vq.push_back(mk(1,1,0,32'h0,  0,0,1, 0,64'h0, 0,0,0,0));
    vq.push_back(mk(0,0,0,32'h0,  0,0,1, 1,64'h0, 0,0,0,0));

    rst_m = 1'b1; rst_b = 1'b1;
    bm.imem_req_ready = 0; bm.imem_resp_valid = 0; bm.imem_resp_data = '0;
    bm.branch_taken = 0; bm.branch_target = '0; bm.id_ready = 0;
    bb.imem_req_ready = 0; bb.imem_resp_valid = 0; bb.imem_resp_data = '0;
    bb.branch_taken = 0; bb.branch_target = '0; bb.id_ready = 0;

    repeat (2) @(negedge clk);
    chk("reset req_valid", 64'(bm.imem_req_valid), 64'h0);
    chk("reset if_valid", 64'(bm.if_valid), 64'h0);
    chk("reset if_pc", bm.if_pc, 64'h0);
    chk("reset if_inst", 64'(bm.if_inst), 64'h0);
    chk("reset fault", 64'(bm.misaligned_fault), 64'h0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst_m = vq[i].rst;
      bm.imem_req_ready  = vq[i].rdy;
      bm.imem_resp_valid = vq[i].rv;
      bm.imem_resp_data  = vq[i].rd;
      bm.branch_taken    = vq[i].bt;
      bm.branch_target   = vq[i].tg;
      bm.id_ready        = vq[i].idr;
      #1;
      chk($sformatf("v%0d req_valid", i), 64'(bm.imem_req_valid), 64'(vq[i].qv));
      if (vq[i].qv) chk($sformatf("v%0d req_addr", i), bm.imem_req_addr, vq[i].qa);
      chk($sformatf("v%0d if_valid", i), 64'(bm.if_valid), 64'(vq[i].iv));
      if (vq[i].iv) begin
        chk($sformatf("v%0d if_pc", i), bm.if_pc, vq[i].pc);
        chk($sformatf("v%0d if_inst", i), 64'(bm.if_inst), 64'(vq[i].ins));
      end
      chk($sformatf("v%0d fault", i), 64'(bm.misaligned_fault), 64'(vq[i].flt));
    end

    // PC wrap from all-ones-3 to 0, then reset in the middle of traffic
    @(negedge clk);
    rst_b = 1'b0; bb.imem_req_ready = 1; bb.id_ready = 1; #1;
    chk("wrap req_valid", 64'(bb.imem_req_valid), 64'h1);
    chk("wrap req_addr", bb.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    bb.imem_resp_valid = 1; bb.imem_resp_data = 32'hAAAA;
    @(negedge clk);
    bb.imem_resp_valid = 0; #1;
    chk("wrap if_pc top", bb.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap if_inst top", 64'(bb.if_inst), 64'hAAAA);
    chk("wrap req_addr 0", bb.imem_req_addr, 64'h0);
    @(negedge clk);
    bb.imem_resp_valid = 1; bb.imem_resp_data = 32'hBBBB;
    @(negedge clk);
    bb.imem_resp_valid = 0; bb.id_ready = 0; #1;
    chk("wrap if_valid 0", 64'(bb.if_valid), 64'h1);
    chk("wrap if_pc 0", bb.if_pc, 64'h0);
    #2 rst_b = 1'b1; #1;
    chk("async reset if_valid", 64'(bb.if_valid), 64'h0);
    chk("async reset req_valid", 64'(bb.imem_req_valid), 64'h0);
    @(negedge clk);
    rst_b = 1'b0; bb.id_ready = 1; bb.imem_req_ready = 1;
    @(negedge clk);
    rst_b = 1'b1; #1;
    chk("reset in wait if_valid", 64'(bb.if_valid), 64'h0);
    @(negedge clk);
    rst_b = 1'b0; bb.imem_req_ready = 0; bb.imem_resp_valid = 1; bb.imem_resp_data = 32'hCCCC; #1;
    chk("post reset req_addr", bb.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    bb.imem_resp_valid = 0; #1;
    chk("stale resp dropped", 64'(bb.if_valid), 64'h0);
    chk("stale resp req_valid", 64'(bb.imem_req_valid), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
